mp_adder_stream: RTL and testbench
==================================

Name: mp_adder_stream

Overview:
- Multi-precision streaming adder stage built around the team's 8-bit ripple-carry adder datapath.
- Consumes a stream of operand byte pairs, least-significant byte first, and chains the carry between bytes of one word.
- Pushes each result byte, with end-of-word carry and overflow flags, into a small output FIFO with a valid/ready interface.
- Upstream is the operand source (tile input pins / sequencer); downstream is the result consumer.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, 2..16.
- MAX_BYTES, 8, maximum bytes per word; the byte that reaches this count is treated as last.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_a  input  8  operand A byte.
- in_b  input  8  operand B byte.
- in_last  input  1  marks the most-significant byte of the word.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept a pair.
- out_sum  output  8  result byte at FIFO head.
- out_last  output  1  head byte is the last byte of its word.
- out_carry  output  1  unsigned carry-out of the word; meaningful only when out_last=1, else 0.
- out_ovf  output  1  signed overflow of the word; meaningful only when out_last=1, else 0.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry.
- err_len  output  1  sticky: a word was truncated at MAX_BYTES.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - FIFO empty; out_valid=0; out_sum/out_last/out_carry/out_ovf=0.
  - in_ready=1; carry_q=0; byte count=0; err_len=0; FSM=IDLE.
- Accept: in_valid && in_ready on a rising edge.
  - in_ready = !full. No bypass: a pop on the same edge does not free space for that edge.
- Arithmetic, per accepted byte:
  - {c, s} = in_a + in_b + cin (9-bit).
  - cin = 0 in IDLE; cin = carry_q in CHAIN.
- FSM:
  - IDLE, accept with eff_last=0: carry_q<=c, count<=1, go to CHAIN.
  - IDLE, accept with eff_last=1: single-byte word; stay in IDLE.
  - CHAIN, accept with eff_last=0: carry_q<=c, count<=count+1.
  - CHAIN, accept with eff_last=1: carry_q<=0, count<=0, go to IDLE.
  - No accept: state, carry_q and count hold.
- eff_last = in_last OR (count+1 == MAX_BYTES).
  - If eff_last=1 only because of the count (in_last=0): set err_len, and the following byte starts a new word.
- FIFO entry pushed on accept: {s, eff_last, eff_last?c:0, eff_last?ovf:0}, where ovf = (in_a[7]==in_b[7]) && (s[7]!=in_a[7]).
- Latency: accepted pair appears at FIFO head one cycle later if the FIFO was empty (registered storage, no combinational in->out path).
- FIFO:
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - Outputs are driven from the head entry. When empty they are 0, not stale.
- Consumer stall (out_ready=0): entries hold; in_ready drops once DEPTH entries are stored; the upstream word pauses mid-chain with carry_q retained.
- err_len clears only on reset.

Test Plan:
- Single byte: in_a=0x7F, in_b=0x01, in_last=1 -> one entry: out_sum=0x80, out_last=1, out_carry=0, out_ovf=1.
- 16-bit word: pairs (0xFF,0x01,last=0) then (0x12,0x34,last=1) -> entries 0x00 (last=0, carry/ovf=0), then 0x47 (last=1, carry=0, ovf=0).
- Unsigned wrap: 16-bit 0xFFFF+0x0001 -> bytes 0x00, 0x00; second entry out_carry=1, out_ovf=0. Next word 0x01+0x01 in IDLE -> 0x02, proving carry_q was cleared.
- Backpressure with DEPTH=4: out_ready=0, stream 6 continuous pairs -> in_ready=0 after the 4th accept. Release out_ready -> all 6 sums emerge in order, with no loss or duplication across the mid-word stall.
- Truncation with MAX_BYTES=8: 9 bytes of 0x01+0x01 with in_last=0 throughout -> 8th entry has out_last=1 and err_len=1; 9th byte has cin=0 and yields 0x02.
- Reset mid-word: assert rst_n=0 in CHAIN with 2 entries queued -> out_valid=0 and in_ready=1 immediately (async). After release, first byte 0x80+0x80 with last=1 -> 0x00, carry=1, ovf=1.

Source files
------------

// File: rtl/mp_adder_stream.sv
// mp_adder_stream: byte-serial multi-precision adder feeding a small valid/ready result FIFO
module mp_adder_stream #(
  parameter int DEPTH     = 4,
  parameter int MAX_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_carry,
  output logic       out_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_len
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_BYTES + 1);
  typedef enum logic {IDLE, CHAIN} state_t;
  state_t          state_q, state_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [10:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [PW:0]     fill_q, fill_d;
  logic            push, pop, cin, c, eff_last, ovf;
  logic [7:0]      s;
  logic [10:0]     entry, head;
  // datapath and handshakes
  always_comb begin
    in_ready  = fill_q != (PW+1)'(DEPTH);
    out_valid = fill_q != '0;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    {c, s}    = {1'b0, in_a} + {1'b0, in_b} + {8'b0, cin};
    eff_last  = in_last || (cnt_q == CW'(MAX_BYTES - 1));
    ovf       = (in_a[7] == in_b[7]) && (s[7] != in_a[7]);
    entry     = {s, eff_last, eff_last & c, eff_last & ovf};
    fill_d    = (push && !pop) ? fill_q + 1'b1 : (pop && !push) ? fill_q - 1'b1 : fill_q;
  end
  // word FSM: a last byte (real or forced by length) always returns to IDLE with carry cleared
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (push & eff_last & ~in_last);
    if (push) begin
      state_d = eff_last ? IDLE : CHAIN;
      carry_d = eff_last ? 1'b0 : c;
      cnt_d   = eff_last ? '0 : cnt_q + CW'(1);
    end
  end
  // outputs: carry-in only chains inside a word, head is zeroed when empty
  always_comb begin
    cin       = (state_q == CHAIN) && carry_q;
    head      = out_valid ? mem_q[rd_q] : '0;
    out_sum   = head[10:3];
    out_last  = head[2];
    out_carry = head[1];
    out_ovf   = head[0];
    err_len   = err_q;
  end
  // state, chain and FIFO control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fill_q  <= fill_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
    end
  end
  // FIFO storage needs no reset since reads are gated by fill level
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= entry;
  end
endmodule

// File: tb/tb_mp_adder_stream.sv
// tb_mp_adder_stream: scoreboard bench with a wide-integer word model
module tb_mp_adder_stream;
  localparam int DEPTH = 4;
  localparam int MAXB  = 8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic       in_last = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_last, out_carry, out_ovf, out_valid, err_len;
  logic [7:0] out_sum;
  int         tests = 0, fails = 0;
  logic [10:0] exp_q [$];
  logic [71:0] acc_a = '0, acc_b = '0;
  int         nb = 0;
  logic       exp_err = 1'b0;
  logic       rnd_done = 1'b0;
  logic [10:0] mon_e;

  mp_adder_stream #(.DEPTH(DEPTH), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_sum(out_sum), .out_last(out_last),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // whole-word reference: operands accumulate as wide integers, each result byte is a slice of their sum
  task automatic model(logic [7:0] a, logic [7:0] b, logic last);
    logic [71:0] sum;
    logic        eff;
    logic [10:0] e;
    eff   = last || (nb + 1 == MAXB);
    acc_a = acc_a | (72'(a) << (8 * nb));
    acc_b = acc_b | (72'(b) << (8 * nb));
    sum   = acc_a + acc_b;
    e[10:3] = sum[8*nb +: 8];
    e[2]    = eff;
    e[1]    = eff ? sum[8*(nb+1)] : 1'b0;
    e[0]    = eff ? ((acc_a[8*nb+7] == acc_b[8*nb+7]) && (sum[8*nb+7] != acc_a[8*nb+7])) : 1'b0;
    exp_q.push_back(e);
    if (eff) begin
      if (!last) exp_err = 1'b1;
      acc_a = '0;
      acc_b = '0;
      nb = 0;
    end else nb++;
  endtask

  task automatic model_clear();
    exp_q.delete();
    acc_a = '0;
    acc_b = '0;
    nb = 0;
    exp_err = 1'b0;
  endtask

  // called just after a rising edge; returns just after the edge that accepted the pair
  task automatic send(logic [7:0] a, logic [7:0] b, logic last);
    bit done = 0;
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model(a, b, last);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept expected accept of %0h+%0h", a, b);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  // monitor: pops the scoreboard on every handshake, and checks zeroed outputs when empty
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %0h expected nothing", {out_sum, out_last, out_carry, out_ovf});
          end else begin
            mon_e = exp_q.pop_front();
            check("out_entry", 32'({out_sum, out_last, out_carry, out_ovf}), 32'(mon_e));
          end
        end
      end else check("empty_zero", 32'({out_sum, out_last, out_carry, out_ovf}), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outs", 32'({out_sum, out_last, out_carry, out_ovf}), 32'd0);
    check("rst_err", 32'(err_len), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h7F, 8'h01, 1'b1);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("single_byte", 32'({out_sum, out_last, out_carry, out_ovf}), 32'({8'h80, 3'b101}));
    drain();
    send(8'hFF, 8'h01, 1'b0);
    send(8'h12, 8'h34, 1'b1);
    drain();
    send(8'hFF, 8'h01, 1'b0);
    send(8'hFF, 8'h00, 1'b1);
    send(8'h01, 8'h01, 1'b1);
    drain();
    out_ready = 1'b0;
    send(8'hFF, 8'h01, 1'b0);
    send(8'hFF, 8'h00, 1'b0);
    send(8'h00, 8'hFF, 1'b0);
    send(8'h12, 8'h34, 1'b0);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(8'hFF, 8'h00, 1'b0);
    send(8'h80, 8'h80, 1'b1);
    drain();
    for (int i = 0; i < 7; i++) send(8'h01, 8'h01, 1'b0);
    check("trunc_err_before", 32'(err_len), 32'd0);
    send(8'h01, 8'h01, 1'b0);
    send(8'h01, 8'h01, 1'b0);
    check("trunc_err_after", 32'(err_len), 32'd1);
    send(8'h00, 8'h00, 1'b1);
    drain();
    fork
      begin
        for (int w = 0; w < 40; w++) begin
          int len;
          len = $urandom_range(1, 10);
          for (int i = 0; i < len; i++) begin
            send(8'($urandom), 8'($urandom), i == len - 1);
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    drain();
    check("rand_err", 32'(err_len), 32'(exp_err));
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0);
    send(8'h33, 8'h44, 1'b0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_err", 32'(err_len), 32'd0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h80, 8'h80, 1'b1);
    check("post_reset_byte", 32'({out_sum, out_last, out_carry, out_ovf}), 32'({8'h00, 3'b111}));
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
